// File: rtl/keymap_access_arbiter_pkg.sv
// rtl/keymap_access_arbiter_pkg.sv - shared widths and FSM state encoding for the keymap arbiter
//
// Purpose: single home for the keymap RAM geometry, the CPU pointer width and
//          the arbiter state encoding, imported by the interface and the top.
// Ports:   none (package).
package keymap_access_arbiter_pkg;

    localparam int KM_ADDR_W = 11;
    localparam int KM_DATA_W = 8;
    localparam int CPU_PTR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KB_RD    = 3'd1,
        ST_KB_CAP   = 3'd2,
        ST_CPU_RD   = 3'd3,
        ST_CPU_CAP  = 3'd4,
        ST_CPU_WR   = 3'd5,
        ST_CPU_WAIT = 3'd6
    } state_t;

endpackage

// File: rtl/keymap_access_arbiter_if.sv
// rtl/keymap_access_arbiter_if.sv - keyboard, CPU and RAM signal bundle around the keymap arbiter
//
// Purpose: groups the translator lookup handshake, the CPU keymap register
//          strobes and the shared keymap RAM port pair.
// Modports:
//   master - the arbiter: takes kb_req/kb_addr, cpu_*, ram_rdata1/2;
//            drives kb_ack, kb_data1/2, kb_overrun, cpu_dout, ram_addr,
//            ram_we1/2, ram_wdata.
//   slave  - the surroundings (translator, register file, RAMs), mirror image.
interface keymap_access_arbiter_if
    import keymap_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = KM_ADDR_W,
    parameter int DATA_W = KM_DATA_W
) ();

    logic              kb_req;
    logic [ADDR_W-1:0] kb_addr;
    logic              kb_ack;
    logic [DATA_W-1:0] kb_data1;
    logic [DATA_W-1:0] kb_data2;
    logic              kb_overrun;

    logic              cpu_read;
    logic              cpu_write;
    logic              cpu_rewind;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we1;
    logic              ram_we2;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata1;
    logic [DATA_W-1:0] ram_rdata2;

    modport master (
        input  kb_req, kb_addr, cpu_read, cpu_write, cpu_rewind, cpu_din,
               ram_rdata1, ram_rdata2,
        output kb_ack, kb_data1, kb_data2, kb_overrun, cpu_dout,
               ram_addr, ram_we1, ram_we2, ram_wdata
    );

    modport slave (
        output kb_req, kb_addr, cpu_read, cpu_write, cpu_rewind, cpu_din,
               ram_rdata1, ram_rdata2,
        input  kb_ack, kb_data1, kb_data2, kb_overrun, cpu_dout,
               ram_addr, ram_we1, ram_we2, ram_wdata
    );

endinterface

// File: rtl/keymap_access_arbiter.sv
// rtl/keymap_access_arbiter.sv - serialises keyboard lookups and CPU keymap access onto the keymap RAMs
//
// Purpose: owns the bank1/bank2 keymap RAM port pair. Keyboard translation
//          lookups read both banks at kb_addr; the CPU uploads/reads the
//          keymap through an auto-incrementing 12-bit pointer whose bit0
//          selects the bank and bits[11:1] the RAM address.
// Ports:
//   clk  - system clock (PS/2 domain)
//   rst  - asynchronous reset, active-high
//   bus  - keymap_access_arbiter_if.master: kb_req/kb_addr -> kb_ack,
//          kb_data1/2, kb_overrun; cpu_read/write/rewind/din -> cpu_dout;
//          ram_addr, ram_we1/2, ram_wdata -> ram_rdata1/2
module keymap_access_arbiter
    import keymap_access_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    keymap_access_arbiter_if.master  bus
);

    state_t                 state;
    state_t                 state_nxt;

    logic [KM_ADDR_W-1:0]   kb_hold;
    logic                   kb_pend;
    logic                   ret_wait;
    logic [CPU_PTR_W-1:0]   cpu_ptr;

    logic [KM_ADDR_W-1:0]   ram_addr_c;
    logic                   ram_we1_c;
    logic                   ram_we2_c;
    logic [KM_DATA_W-1:0]   ram_wdata_c;

    logic                   kb_cap;
    logic                   cpu_cap;
    logic                   ret_wait_set;
    logic                   ret_wait_clr;
    logic                   ptr_inc;
    logic                   ptr_clr;

    // A request is accepted in every state; a second one before the first is
    // served replaces the address and is flagged, the older lookup is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_hold        <= '0;
            kb_pend        <= 1'b0;
            bus.kb_overrun <= 1'b0;
        end else if (bus.kb_req) begin
            kb_hold <= bus.kb_addr;
            kb_pend <= 1'b1;
            if (kb_pend) begin
                bus.kb_overrun <= 1'b1;
            end
        end else if (kb_cap) begin
            kb_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ret_wait     <= 1'b0;
            cpu_ptr      <= '0;
            bus.kb_ack   <= 1'b0;
            bus.kb_data1 <= '0;
            bus.kb_data2 <= '0;
            bus.cpu_dout <= '0;
        end else begin
            state      <= state_nxt;
            bus.kb_ack <= kb_cap;
            if (kb_cap) begin
                bus.kb_data1 <= bus.ram_rdata1;
                bus.kb_data2 <= bus.ram_rdata2;
            end
            if (cpu_cap) begin
                bus.cpu_dout <= cpu_ptr[0] ? bus.ram_rdata2 : bus.ram_rdata1;
            end
            if (ret_wait_set) begin
                ret_wait <= 1'b1;
            end else if (ret_wait_clr) begin
                ret_wait <= 1'b0;
            end
            if (ptr_clr) begin
                cpu_ptr <= '0;
            end else if (ptr_inc) begin
                cpu_ptr <= cpu_ptr + 12'd1;
            end
        end
    end

    // The address is also held through the *_RD states so the RAM registers
    // the same location twice; the capture state then sees the data of the
    // newest kb_hold even if a request overwrote it while leaving IDLE.
    always_comb begin
        state_nxt    = state;
        ram_addr_c   = '0;
        ram_we1_c    = 1'b0;
        ram_we2_c    = 1'b0;
        ram_wdata_c  = '0;
        kb_cap       = 1'b0;
        cpu_cap      = 1'b0;
        ret_wait_set = 1'b0;
        ret_wait_clr = 1'b0;
        ptr_inc      = 1'b0;
        ptr_clr      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (kb_pend) begin
                    ram_addr_c = kb_hold;
                    state_nxt  = ST_KB_RD;
                end else if (bus.cpu_rewind) begin
                    ptr_clr = 1'b1;
                end else if (bus.cpu_read) begin
                    ram_addr_c = cpu_ptr[CPU_PTR_W-1:1];
                    state_nxt  = ST_CPU_RD;
                end else if (bus.cpu_write) begin
                    ram_addr_c = cpu_ptr[CPU_PTR_W-1:1];
                    state_nxt  = ST_CPU_WR;
                end
            end
            ST_KB_RD: begin
                ram_addr_c = kb_hold;
                state_nxt  = ST_KB_CAP;
            end
            ST_KB_CAP: begin
                kb_cap = 1'b1;
                if (ret_wait) begin
                    ret_wait_clr = 1'b1;
                    state_nxt    = ST_CPU_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CPU_RD: begin
                ram_addr_c = cpu_ptr[CPU_PTR_W-1:1];
                state_nxt  = ST_CPU_CAP;
            end
            ST_CPU_CAP: begin
                cpu_cap   = 1'b1;
                state_nxt = ST_CPU_WAIT;
            end
            ST_CPU_WR: begin
                ram_addr_c  = cpu_ptr[CPU_PTR_W-1:1];
                ram_we1_c   = ~cpu_ptr[0];
                ram_we2_c   = cpu_ptr[0];
                ram_wdata_c = bus.cpu_din;
                state_nxt   = ST_CPU_WAIT;
            end
            ST_CPU_WAIT: begin
                // Keyboard is served inside a long CPU strobe; the pointer
                // only moves once the strobe has ended.
                if (kb_pend) begin
                    ret_wait_set = 1'b1;
                    ram_addr_c   = kb_hold;
                    state_nxt    = ST_KB_RD;
                end else if (!bus.cpu_read && !bus.cpu_write) begin
                    ptr_inc   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_we1   = ram_we1_c;
    assign bus.ram_we2   = ram_we2_c;
    assign bus.ram_wdata = ram_wdata_c;

endmodule

// File: tb/tb_keymap_access_arbiter.sv
// tb/tb_keymap_access_arbiter.sv - self-checking bench for keymap_access_arbiter
module tb_keymap_access_arbiter;

    localparam int OP_REW = 0;
    localparam int OP_WR  = 1;
    localparam int OP_RD  = 2;

    typedef struct {
        int         op;
        logic [7:0] din;
        logic [7:0] exp;
        int         bank;
        int         addr;
        int         hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    keymap_access_arbiter_if bus ();

    keymap_access_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RAMs plus a bench-side loading port
    logic [7:0]  ram1 [0:2047];
    logic [7:0]  ram2 [0:2047];
    logic        bd_we;
    logic [10:0] bd_addr;
    logic [7:0]  bd_d1;
    logic [7:0]  bd_d2;

    always @(posedge clk) begin
        if (bus.ram_we1) ram1[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_we2) ram2[bus.ram_addr] <= bus.ram_wdata;
        if (bd_we) begin
            ram1[bd_addr] <= bd_d1;
            ram2[bd_addr] <= bd_d2;
        end
        bus.ram_rdata1 <= ram1[bus.ram_addr];
        bus.ram_rdata2 <= ram2[bus.ram_addr];
    end

    // Reference model: keymap contents and CPU pointer
    logic [7:0]  m1 [0:2047];
    logic [7:0]  m2 [0:2047];
    logic [11:0] tb_ptr;

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;
    int both_we = 0;

    always @(negedge clk) begin
        if (bus.ram_we1 || bus.ram_we2) we_pulses++;
        if (bus.ram_we1 && bus.ram_we2) both_we++;
    end

    function automatic logic [7:0] model_at(input logic [11:0] p);
        return p[0] ? m2[p[11:1]] : m1[p[11:1]];
    endfunction

    function automatic logic [7:0] ram_at(input logic [11:0] p);
        return p[0] ? ram2[p[11:1]] : ram1[p[11:1]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic bd_write(input logic [10:0] a, input logic [7:0] d1, input logic [7:0] d2);
        bd_addr = a; bd_d1 = d1; bd_d2 = d2; bd_we = 1'b1;
        m1[a] = d1; m2[a] = d2;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic kb_lookup(input logic [10:0] a, input int lo, input int hi, input string tag);
        logic [7:0] e1, e2;
        int n;
        bit seen;
        e1 = m1[a];
        e2 = m2[a];
        bus.kb_addr = a;
        bus.kb_req  = 1'b1;
        @(negedge clk);
        bus.kb_req = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            if (bus.kb_ack === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_ack_seen"}, seen, 1);
        if (seen) begin
            check_range({tag, "_latency"}, n, lo, hi);
            check({tag, "_data1"}, bus.kb_data1, e1);
            check({tag, "_data2"}, bus.kb_data2, e2);
            @(negedge clk);
            check({tag, "_ack_pulse"}, bus.kb_ack, 0);
        end
    endtask

    task automatic do_rewind();
        bus.cpu_rewind = 1'b1;
        @(negedge clk);
        bus.cpu_rewind = 1'b0;
        @(negedge clk);
        tb_ptr = 12'h000;
    endtask

    task automatic cpu_read_op(input int hold, input int gap, input string tag);
        int w0;
        logic [7:0] e;
        e  = model_at(tb_ptr);
        w0 = we_pulses;
        bus.cpu_read = 1'b1;
        repeat (hold) @(negedge clk);
        bus.cpu_read = 1'b0;
        repeat (gap) @(negedge clk);
        check({tag, "_dout"}, bus.cpu_dout, e);
        check({tag, "_no_write"}, we_pulses - w0, 0);
        tb_ptr = tb_ptr + 12'd1;
    endtask

    task automatic cpu_write_op(input int hold, input int gap, input logic [7:0] d, input string tag);
        int w0;
        w0 = we_pulses;
        bus.cpu_din   = d;
        bus.cpu_write = 1'b1;
        repeat (hold) @(negedge clk);
        bus.cpu_write = 1'b0;
        repeat (gap) @(negedge clk);
        check({tag, "_one_write"}, we_pulses - w0, 1);
        check({tag, "_ram"}, ram_at(tb_ptr), d);
        if (tb_ptr[0]) m2[tb_ptr[11:1]] = d;
        else m1[tb_ptr[11:1]] = d;
        tb_ptr = tb_ptr + 12'd1;
    endtask

    vec_t vecs [12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [7:0] a1, a2;
        int w0;

        vecs[0]  = '{OP_REW, 8'h00, 8'h00, 0, 0, 1};
        vecs[1]  = '{OP_WR,  8'h11, 8'h00, 0, 0, 1};
        vecs[2]  = '{OP_WR,  8'h22, 8'h00, 1, 0, 3};
        vecs[3]  = '{OP_WR,  8'h33, 8'h00, 0, 1, 7};
        vecs[4]  = '{OP_WR,  8'h44, 8'h00, 1, 1, 1};
        vecs[5]  = '{OP_WR,  8'h66, 8'h00, 0, 2, 2};
        vecs[6]  = '{OP_REW, 8'h00, 8'h00, 0, 0, 1};
        vecs[7]  = '{OP_RD,  8'h00, 8'h11, 0, 0, 1};
        vecs[8]  = '{OP_RD,  8'h00, 8'h22, 0, 0, 5};
        vecs[9]  = '{OP_RD,  8'h00, 8'h33, 0, 0, 1};
        vecs[10] = '{OP_RD,  8'h00, 8'h44, 0, 0, 9};
        vecs[11] = '{OP_RD,  8'h00, 8'h66, 0, 0, 1};

        rst = 1'b1;
        bus.kb_req = 1'b0; bus.kb_addr = '0;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_rewind = 1'b0; bus.cpu_din = '0;
        bd_we = 1'b0; bd_addr = '0; bd_d1 = '0; bd_d2 = '0;
        tb_ptr = 12'h000;
        repeat (3) @(negedge clk);

        check("rst_kb_ack", bus.kb_ack, 0);
        check("rst_kb_data1", bus.kb_data1, 0);
        check("rst_kb_data2", bus.kb_data2, 0);
        check("rst_kb_overrun", bus.kb_overrun, 0);
        check("rst_cpu_dout", bus.cpu_dout, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_we", {bus.ram_we1, bus.ram_we2}, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 2048; i++) begin
            bd_write(i[10:0], 8'($urandom), 8'($urandom));
        end
        bd_write(11'h123, 8'h45, 8'h9A);
        bd_write(11'h010, 8'hA1, 8'hA2);
        bd_write(11'h020, 8'hB1, 8'hB2);
        repeat (2) @(negedge clk);

        // Lookup from IDLE
        kb_lookup(11'h123, 3, 3, "t1");
        check("t1_data1_const", bus.kb_data1, 8'h45);
        check("t1_data2_const", bus.kb_data2, 8'h9A);
        repeat (2) @(negedge clk);

        // Upload and readback table
        for (int i = 0; i < 12; i++) begin
            case (vecs[i].op)
                OP_REW: do_rewind();
                OP_WR: begin
                    cpu_write_op(vecs[i].hold, 6, vecs[i].din, $sformatf("vec%0d", i));
                    check($sformatf("vec%0d_loc", i),
                          vecs[i].bank != 0 ? ram2[vecs[i].addr] : ram1[vecs[i].addr],
                          vecs[i].din);
                end
                default: begin
                    cpu_read_op(vecs[i].hold, 6, $sformatf("vec%0d", i));
                    check($sformatf("vec%0d_const", i), bus.cpu_dout, vecs[i].exp);
                end
            endcase
        end

        // Long read strobe with a keyboard lookup landing inside it
        a1 = model_at(tb_ptr);
        w0 = we_pulses;
        fork
            begin
                bus.cpu_read = 1'b1;
                repeat (20) @(negedge clk);
                bus.cpu_read = 1'b0;
                repeat (8) @(negedge clk);
            end
            begin
                repeat (2) @(negedge clk);
                kb_lookup(11'h123, 3, 5, "t4_kb");
            end
        join
        check("t4_dout", bus.cpu_dout, a1);
        check("t4_no_write", we_pulses - w0, 0);
        tb_ptr = tb_ptr + 12'd1;
        cpu_read_op(1, 6, "t4_next");

        // Back-to-back requests: overrun, one ack with the later address
        check("t5_overrun_before", bus.kb_overrun, 0);
        bus.kb_addr = 11'h010; bus.kb_req = 1'b1;
        @(negedge clk);
        bus.kb_addr = 11'h020;
        @(negedge clk);
        bus.kb_req = 1'b0;
        acks = 0; a1 = '0; a2 = '0;
        repeat (10) begin
            if (bus.kb_ack === 1'b1) begin
                acks++;
                a1 = bus.kb_data1;
                a2 = bus.kb_data2;
            end
            @(negedge clk);
        end
        check("t5_ack_count", acks, 1);
        check("t5_data1", a1, m1[11'h020]);
        check("t5_data2", a2, m2[11'h020]);
        check("t5_overrun", bus.kb_overrun, 1);

        // Randomised traffic: CPU in the low half, keyboard in the high half
        do_rewind();
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    if ($urandom_range(0, 1) == 0)
                        cpu_read_op($urandom_range(4, 6), $urandom_range(8, 10), $sformatf("rnd_rd%0d", k));
                    else
                        cpu_write_op($urandom_range(4, 6), $urandom_range(8, 10), 8'($urandom),
                                     $sformatf("rnd_wr%0d", k));
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    logic [10:0] ka;
                    repeat ($urandom_range(8, 15)) @(negedge clk);
                    ka = {1'b1, 10'($urandom)};
                    kb_lookup(ka, 3, 5, $sformatf("rnd_kb%0d", k));
                end
            end
        join

        // Walk the pointer to 0xFFF, then check wrap
        do_rewind();
        for (int k = 0; k < 4095; k++) begin
            cpu_read_op(1, 4, "walk");
        end
        cpu_write_op(1, 6, 8'hC3, "t6_wr_fff");
        check("t6_bank2_7ff", ram2[11'h7FF], 8'hC3);
        cpu_read_op(1, 6, "t6_wrapped");

        // Reset in the middle of a write cycle (pointer now 1 -> bank2[0])
        a2 = m2[0];
        w0 = we_pulses;
        bus.cpu_din = 8'hEE;
        bus.cpu_write = 1'b1;
        @(posedge clk);
        #1;
        check("t6_we_started", bus.ram_we2, 1);
        rst = 1'b1;
        #1;
        bus.cpu_write = 1'b0;
        @(negedge clk);
        check("t6r_we", {bus.ram_we1, bus.ram_we2}, 0);
        check("t6r_ram_addr", bus.ram_addr, 0);
        check("t6r_wdata", bus.ram_wdata, 0);
        check("t6r_kb_ack", bus.kb_ack, 0);
        check("t6r_kb_data1", bus.kb_data1, 0);
        check("t6r_kb_data2", bus.kb_data2, 0);
        check("t6r_overrun", bus.kb_overrun, 0);
        check("t6r_cpu_dout", bus.cpu_dout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6r_no_write_count", we_pulses - w0, 0);
        check("t6r_bank2_0_kept", ram2[0], a2);
        tb_ptr = 12'h000;
        cpu_read_op(1, 6, "t6r_ptr_zero");

        check("both_we_never", both_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
